// File: rtl/control_unit_pipe_if.sv
// Fetch-to-decode bus for control_unit_pipe: instruction words and pipeline
// controls in, registered control word, opcode and immediate out.
interface control_unit_pipe_if #(
  parameter int INSTR_W = 16
);
  logic [INSTR_W-1:0] instr_in;
  logic               instr_valid;
  logic               stall;
  logic               flush;
  logic [8:0]         ctrl_out;
  logic [4:0]         opcode_out;
  logic [INSTR_W-1:0] imm_out;
  logic               ctrl_valid;
  logic               imm_valid;
  logic               busy;

  modport master (
    output instr_in, instr_valid, stall, flush,
    input  ctrl_out, opcode_out, imm_out, ctrl_valid, imm_valid, busy
  );

  modport slave (
    input  instr_in, instr_valid, stall, flush,
    output ctrl_out, opcode_out, imm_out, ctrl_valid, imm_valid, busy
  );
endinterface

// File: rtl/control_unit_pipe.sv
// Registered opcode decoder that assembles opcode+immediate instruction pairs
// and issues control, opcode and immediate together; honours stall and flush.
module control_unit_pipe #(
  parameter int INSTR_W = 16,
  parameter bit IMM_EN  = 1'b1
) (
  input logic              clk,
  input logic              rst,
  control_unit_pipe_if.slave bus
);

  typedef enum logic {S_OP, S_IMM} state_e;

  state_e             state_q, state_d;
  logic [8:0]         ctrl_q, ctrl_d;
  logic [4:0]         opc_q, opc_d;
  logic [INSTR_W-1:0] imm_q, imm_d;
  logic               ctrl_valid_q, ctrl_valid_d;
  logic               imm_valid_q, imm_valid_d;
  logic [8:0]         pend_ctrl_q, pend_ctrl_d;
  logic [4:0]         pend_opc_q, pend_opc_d;

  logic [4:0] opc_in;
  logic [8:0] dec;

  assign opc_in = bus.instr_in[INSTR_W-1 -: 5];

  function automatic logic [8:0] decode(input logic [4:0] o);
    logic [8:0] c;
    c    = '0;
    c[8] = (o[4:2] == 3'b011) && !o[0];
    c[7] = (o[4:2] == 3'b011) &&  o[0];
    c[6] = (o == 5'b01101);
    c[5] = (o == 5'b01100);
    c[4] = (o == 5'b01111);
    c[3] = (o == 5'b01110);
    c[2] = (o == 5'b00111);
    c[1] = o inside {5'b00001, 5'b11111, 5'b11101, 5'b00011, 5'b11100,
                     5'b00111, 5'b10100, 5'b10101, 5'b01110};
    c[0] = (o[4:3] == 2'b10) ||
           (o inside {5'b01101, 5'b01111, 5'b00101, 5'b00111,
                      5'b00010, 5'b00000, 5'b01110});
    return c;
  endfunction

  assign dec = decode(opc_in);

  always_comb begin
    // NOTE: every next-state signal defaults to its held value first, so no
    // path through the branches below can infer a latch.
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    opc_d        = opc_q;
    imm_d        = imm_q;
    ctrl_valid_d = ctrl_valid_q;
    imm_valid_d  = imm_valid_q;
    pend_ctrl_d  = pend_ctrl_q;
    pend_opc_d   = pend_opc_q;

    if (bus.flush) begin
      state_d      = S_OP;
      ctrl_d       = '0;
      opc_d        = '0;
      imm_d        = '0;
      ctrl_valid_d = 1'b0;
      imm_valid_d  = 1'b0;
      pend_ctrl_d  = '0;
      pend_opc_d   = '0;
    end else if (!bus.stall) begin
      // Bubble unless a word completes an instruction this cycle.
      ctrl_d       = '0;
      opc_d        = '0;
      imm_d        = '0;
      ctrl_valid_d = 1'b0;
      imm_valid_d  = 1'b0;
      if (bus.instr_valid) begin
        unique case (state_q)
          S_OP: begin
            if (IMM_EN && dec[1]) begin
              pend_ctrl_d = dec;
              pend_opc_d  = opc_in;
              state_d     = S_IMM;
            end else begin
              ctrl_d       = dec;
              opc_d        = opc_in;
              ctrl_valid_d = 1'b1;
            end
          end
          S_IMM: begin
            ctrl_d       = pend_ctrl_q;
            opc_d        = pend_opc_q;
            imm_d        = bus.instr_in;
            ctrl_valid_d = 1'b1;
            imm_valid_d  = 1'b1;
            state_d      = S_OP;
          end
          default: state_d = S_OP;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q      <= S_OP;
      ctrl_q       <= '0;
      opc_q        <= '0;
      imm_q        <= '0;
      ctrl_valid_q <= 1'b0;
      imm_valid_q  <= 1'b0;
      pend_ctrl_q  <= '0;
      pend_opc_q   <= '0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      opc_q        <= opc_d;
      imm_q        <= imm_d;
      ctrl_valid_q <= ctrl_valid_d;
      imm_valid_q  <= imm_valid_d;
      pend_ctrl_q  <= pend_ctrl_d;
      pend_opc_q   <= pend_opc_d;
    end
  end

  assign bus.ctrl_out   = ctrl_q;
  assign bus.opcode_out = opc_q;
  assign bus.imm_out    = imm_q;
  assign bus.ctrl_valid = ctrl_valid_q;
  assign bus.imm_valid  = imm_valid_q;
  assign bus.busy       = (state_q == S_IMM);

endmodule

// File: tb/tb_control_unit_pipe.sv
// Bench for control_unit_pipe: directed scenarios plus random traffic checked
// against a pattern-table decoder and a pending-opcode instruction model.
module tb_control_unit_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  control_unit_pipe_if #(.INSTR_W(16)) bus0 ();
  control_unit_pipe_if #(.INSTR_W(16)) bus1 ();

  control_unit_pipe #(.INSTR_W(16), .IMM_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  control_unit_pipe #(.INSTR_W(16), .IMM_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: outputs plus "an opcode is waiting for its immediate".
  logic [8:0]  m_ctrl;
  logic [4:0]  m_opc;
  logic [15:0] m_imm;
  logic        m_cv, m_iv, m_busy;
  logic [4:0]  m_pend;

  function automatic bit match(input logic [4:0] o, input string p);
    for (int i = 0; i < 5; i++) begin
      if (p[i] == "x") continue;
      if ((p[i] == "1") != o[4-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [8:0] ref_decode(input logic [4:0] o);
    string b1 [9] = '{"00001","11111","11101","00011","11100","00111","10100","10101","01110"};
    string b0 [8] = '{"10xxx","01101","01111","00101","00111","00010","00000","01110"};
    logic [8:0] r;
    r    = '0;
    r[8] = match(o, "011x0");
    r[7] = match(o, "011x1");
    r[6] = match(o, "01101");
    r[5] = match(o, "01100");
    r[4] = match(o, "01111");
    r[3] = match(o, "01110");
    r[2] = match(o, "00111");
    for (int i = 0; i < 9; i++) if (match(o, b1[i])) r[1] = 1'b1;
    for (int i = 0; i < 8; i++) if (match(o, b0[i])) r[0] = 1'b1;
    return r;
  endfunction

  task automatic model_clear();
    m_ctrl = '0; m_opc = '0; m_imm = '0;
    m_cv = 1'b0; m_iv = 1'b0;
  endtask

  task automatic model_step(input logic r, v, s, f, input logic [15:0] w);
    logic [8:0] c;
    if (r || f) begin
      model_clear();
      m_busy = 1'b0;
      m_pend = '0;
    end else if (!s) begin
      model_clear();
      if (v) begin
        if (m_busy) begin
          m_ctrl = ref_decode(m_pend); m_opc = m_pend; m_imm = w;
          m_cv = 1'b1; m_iv = 1'b1; m_busy = 1'b0;
        end else begin
          c = ref_decode(w[15:11]);
          if (c[1]) begin
            m_busy = 1'b1;
            m_pend = w[15:11];
          end else begin
            m_ctrl = c; m_opc = w[15:11]; m_cv = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic logic [11:0] obs_main0();
    return {bus0.busy, bus0.ctrl_valid, bus0.imm_valid, bus0.ctrl_out};
  endfunction
  function automatic logic [20:0] obs_pay0();
    return {bus0.opcode_out, bus0.imm_out};
  endfunction
  function automatic logic [11:0] exp_main();
    return {m_busy, m_cv, m_iv, m_ctrl};
  endfunction
  function automatic logic [20:0] exp_pay();
    return {m_opc, m_imm};
  endfunction
  function automatic logic [11:0] mk(input logic b, cv, iv, input logic [8:0] c);
    return {b, cv, iv, c};
  endfunction

  // Drive one cycle on bus0; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic r, v, s, f, input logic [15:0] w);
    rst = r;
    bus0.instr_valid = v; bus0.stall = s; bus0.flush = f; bus0.instr_in = w;
    @(posedge clk);
    model_step(r, v, s, f, w);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      bus1.instr_valid = 1'b1; bus1.instr_in = 16'($urandom);
      step(1'b1, 1'b1, 1'b0, 1'b0, 16'($urandom));
      n_total++;
      if ({obs_main0(), obs_pay0()} !== 33'd0) $display("FAIL reset%0d: got %h want 0", i, {obs_main0(), obs_pay0()});
      else n_pass++;
    end
    bus1.instr_valid = 1'b0;
  endtask

  task automatic test_single_word();
    logic [15:0] w [3] = '{16'h8000, 16'h6000, 16'h6800};
    logic [8:0]  c [3] = '{9'h001, 9'h120, 9'h0C1};
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, w[i]);
      n_total++;
      if (obs_main0() !== mk(1'b0, 1'b1, 1'b0, c[i]) || obs_pay0() !== {w[i][15:11], 16'h0})
        $display("FAIL single%0d: got %h/%h want %h/%h", i, obs_main0(), obs_pay0(),
                 mk(1'b0, 1'b1, 1'b0, c[i]), {w[i][15:11], 16'h0});
      else n_pass++;
    end
  endtask

  task automatic test_two_word();
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h3800);
    n_total++;
    if (obs_main0() !== mk(1'b1, 1'b0, 1'b0, 9'h000)) $display("FAIL ldm_word1: got %h want %h", obs_main0(), mk(1'b1, 1'b0, 1'b0, 9'h000));
    else n_pass++;
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h00AB);
    n_total++;
    if (obs_main0() !== mk(1'b0, 1'b1, 1'b1, 9'h007) || obs_pay0() !== {5'b00111, 16'h00AB})
      $display("FAIL ldm_word2: got %h/%h want %h/%h", obs_main0(), obs_pay0(), mk(1'b0, 1'b1, 1'b1, 9'h007), {5'b00111, 16'h00AB});
    else n_pass++;
  endtask

  task automatic test_stall();
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h7000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 16'($urandom));
      n_total++;
      if (obs_main0() !== mk(1'b1, 1'b0, 1'b0, 9'h000)) $display("FAIL stall%0d: got %h want %h", i, obs_main0(), mk(1'b1, 1'b0, 1'b0, 9'h000));
      else n_pass++;
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
    n_total++;
    if (obs_main0() !== mk(1'b0, 1'b1, 1'b1, 9'h10B) || obs_pay0() !== {5'b01110, 16'h1234})
      $display("FAIL ldd_after_stall: got %h/%h want %h/%h", obs_main0(), obs_pay0(), mk(1'b0, 1'b1, 1'b1, 9'h10B), {5'b01110, 16'h1234});
    else n_pass++;
    // A stall must also freeze a valid output, not just a pending opcode.
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h8000);
    n_total++;
    if (obs_main0() !== mk(1'b0, 1'b1, 1'b1, 9'h10B) || obs_pay0() !== {5'b01110, 16'h1234})
      $display("FAIL stall_hold_valid: got %h/%h want %h/%h", obs_main0(), obs_pay0(), mk(1'b0, 1'b1, 1'b1, 9'h10B), {5'b01110, 16'h1234});
    else n_pass++;
  endtask

  task automatic test_flush();
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h3800);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h00AB);
    n_total++;
    if ({obs_main0(), obs_pay0()} !== 33'd0) $display("FAIL flush_nop: got %h want 0", {obs_main0(), obs_pay0()});
    else n_pass++;
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h00AB);
    n_total++;
    if (obs_main0() !== mk(1'b0, 1'b1, 1'b0, 9'h001) || obs_pay0() !== 21'd0)
      $display("FAIL flush_next_opcode: got %h/%h want %h/0", obs_main0(), obs_pay0(), mk(1'b0, 1'b1, 1'b0, 9'h001));
    else n_pass++;
  endtask

  task automatic test_rst_busy();
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h3800);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'($urandom));
    n_total++;
    if ({obs_main0(), obs_pay0()} !== 33'd0) $display("FAIL rst_busy: got %h want 0", {obs_main0(), obs_pay0()});
    else n_pass++;
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h8000);
    n_total++;
    if (obs_main0() !== mk(1'b0, 1'b1, 1'b0, 9'h001)) $display("FAIL rst_then_op: got %h want %h", obs_main0(), mk(1'b0, 1'b1, 1'b0, 9'h001));
    else n_pass++;
  endtask

  task automatic test_imm_disabled();
    logic [15:0] w [2] = '{16'h3800, 16'h00AB};
    logic [8:0]  c [2] = '{9'h007, 9'h001};
    for (int i = 0; i < 2; i++) begin
      bus1.instr_valid = 1'b1; bus1.instr_in = w[i];
      @(posedge clk); #1;
      n_total++;
      if ({bus1.busy, bus1.ctrl_valid, bus1.imm_valid, bus1.ctrl_out} !== mk(1'b0, 1'b1, 1'b0, c[i]) ||
          {bus1.opcode_out, bus1.imm_out} !== {w[i][15:11], 16'h0})
        $display("FAIL imm_disabled%0d: got %h/%h want %h/%h", i,
                 {bus1.busy, bus1.ctrl_valid, bus1.imm_valid, bus1.ctrl_out}, {bus1.opcode_out, bus1.imm_out},
                 mk(1'b0, 1'b1, 1'b0, c[i]), {w[i][15:11], 16'h0});
      else n_pass++;
    end
    bus1.instr_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [4:0] hot [10] = '{5'b00001, 5'b00111, 5'b01110, 5'b11111, 5'b01100,
                             5'b01101, 5'b01111, 5'b10000, 5'b00101, 5'b00010};
    logic [4:0]  o;
    logic [15:0] w;
    int          errs;
    errs = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 400; i++) begin
      o = ($urandom % 2 == 0) ? hot[$urandom % 10] : 5'($urandom);
      w = {o, 11'($urandom)};
      step(($urandom % 97) == 0, ($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 16) == 0, w);
      n_total++;
      if (obs_main0() !== exp_main() || (m_cv && obs_pay0() !== exp_pay())) begin
        if (errs < 10) $display("FAIL random%0d: got %h/%h want %h/%h", i, obs_main0(), obs_pay0(), exp_main(), exp_pay());
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    bus0.instr_valid = 1'b0; bus0.stall = 1'b0; bus0.flush = 1'b0; bus0.instr_in = '0;
    bus1.instr_valid = 1'b0; bus1.stall = 1'b0; bus1.flush = 1'b0; bus1.instr_in = '0;
    m_busy = 1'b0; m_pend = '0;
    model_clear();
    test_reset();
    test_single_word();
    test_two_word();
    test_stall();
    test_flush();
    test_rst_busy();
    test_imm_disabled();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
